// File: rtl/proc_pkg.sv
// Shared types and constants for the instruction sequencer and its front-panel input logic.
package proc_pkg;

    localparam int PC_W_DEFAULT = 12;
    localparam logic [3:0] HALT_OP = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MUL_WAIT,
        S_WB,
        S_HALT
    } state_t;

    function automatic logic is_halt(input logic [15:0] word);
        return word[15:12] == HALT_OP;
    endfunction

endpackage

// File: rtl/step_debouncer.sv
// Turns the raw active-low step key into a single-cycle pulse on its press edge.
// Optional STEP_DEBOUNCE_EN adds a stable-level filter of DEBOUNCE_CYC clocks.
module step_debouncer #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic srst,
    input  logic step_n,
    output logic step_pulse
);

    // Two-stage synchronizer; reset to the released level so reset never looks like a press.
    logic [1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], step_n};
        end
    end

`ifdef STEP_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;

    logic [CNT_W-1:0] cnt_reg;
    logic             stable_reg;
    logic             prev_reg;

    // The filtered level only follows the input after it has differed for DEBOUNCE_CYC clocks.
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg    <= '0;
            stable_reg <= 1'b1;
            prev_reg   <= 1'b1;
        end else begin
            prev_reg <= stable_reg;
            if (sync_reg[1] == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_W'(DEBOUNCE_CYC - 1)) begin
                stable_reg <= sync_reg[1];
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign step_pulse = prev_reg & ~stable_reg;
`else
    // Fast build: no filtering, the debounce period is deliberately ignored.
    localparam int unused_debounce_cyc = DEBOUNCE_CYC;

    logic prev_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            prev_reg <= 1'b1;
        end else begin
            prev_reg <= sync_reg[1];
        end
    end

    assign step_pulse = prev_reg & ~sync_reg[1];
`endif

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: owns the PC, fetches, and emits per-phase datapath strobes.
// Build option STEP_DEBOUNCE_EN enables step-key debouncing in step_debouncer.
module instr_sequencer
    import proc_pkg::*;
#(
    parameter int PC_W         = PC_W_DEFAULT,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int MUL_CYC      = 4
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic            step_n,
    input  logic            run,
    input  logic [15:0]     instr,
    input  logic            jump_en,
    input  logic            branch_en,
    input  logic            mul_op,
    input  logic            zero_a,
    input  logic [PC_W-1:0] target_b,
    input  logic [PC_W-1:0] j_imm,
    output logic [PC_W-1:0] pc,
    output logic            imem_rd,
    output logic [15:0]     ir,
    output logic            ir_valid,
    output logic            stage_adv,
    output logic            mul_en,
    output logic            reg_we,
    output logic            busy,
    output logic            halted
);

    localparam int CNT_W = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYC - 1);

    logic step_pulse;

    step_debouncer #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_step (
        .clk       (CLOCK_50),
        .srst      (reset),
        .step_n    (step_n),
        .step_pulse(step_pulse)
    );

    state_t           state_reg, state_next;
    logic [PC_W-1:0]  pc_reg, pc_next;
    logic [15:0]      ir_reg, ir_next;
    logic             ir_valid_reg, ir_valid_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            pc_reg       <= '0;
            ir_reg       <= '0;
            ir_valid_reg <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            ir_reg       <= ir_next;
            ir_valid_reg <= ir_valid_next;
            cnt_reg      <= cnt_next;
        end
    end

    // Step pulses are only looked at in IDLE, so presses while busy or halted are simply lost.
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        ir_next       = ir_reg;
        ir_valid_next = ir_valid_reg;
        cnt_next      = cnt_reg;
        unique case (state_reg)
            S_IDLE: begin
                if (step_pulse || run) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                state_next = S_DECODE;
            end
            S_DECODE: begin
                ir_next       = instr;
                ir_valid_next = 1'b1;
                state_next    = is_halt(instr) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (mul_op) begin
                    cnt_next   = MUL_LOAD;
                    state_next = S_MUL_WAIT;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MUL_WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = S_WB;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            S_WB: begin
                // Jump beats branch; the increment wraps naturally at the PC width.
                if (jump_en) begin
                    pc_next = j_imm;
                end else if (branch_en && zero_a) begin
                    pc_next = target_b;
                end else begin
                    pc_next = pc_reg + 1'b1;
                end
                state_next = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign pc        = pc_reg;
    assign ir        = ir_reg;
    assign ir_valid  = ir_valid_reg;
    assign imem_rd   = (state_reg == S_FETCH);
    assign stage_adv = (state_reg == S_EXEC);
    assign mul_en    = (state_reg == S_MUL_WAIT);
    assign reg_we    = (state_reg == S_WB);
    assign halted    = (state_reg == S_HALT);
    assign busy      = (state_reg == S_FETCH) || (state_reg == S_DECODE) ||
                       (state_reg == S_EXEC)  || (state_reg == S_MUL_WAIT) ||
                       (state_reg == S_WB);

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: table-driven single steps plus run/halt and abort sequences.
module tb_instr_sequencer;

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b1;
    logic        step_n   = 1'b1;
    logic        run      = 1'b0;
    logic        jump_en  = 1'b0;
    logic        branch_en = 1'b0;
    logic        mul_op   = 1'b0;
    logic        zero_a   = 1'b0;
    logic [11:0] target_b = '0;
    logic [11:0] j_imm    = '0;
    logic [15:0] tbl_instr = '0;
    logic [15:0] mem_instr = '0;
    logic        use_mem  = 1'b0;
    logic [15:0] instr;

    logic [11:0] pc;
    logic        imem_rd;
    logic [15:0] ir;
    logic        ir_valid;
    logic        stage_adv;
    logic        mul_en;
    logic        reg_we;
    logic        busy;
    logic        halted;

    assign instr = use_mem ? mem_instr : tbl_instr;

    always #5 CLOCK_50 = ~CLOCK_50;

    instr_sequencer #(
        .PC_W(12),
        .DEBOUNCE_CYC(500000),
        .MUL_CYC(4)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .step_n   (step_n),
        .run      (run),
        .instr    (instr),
        .jump_en  (jump_en),
        .branch_en(branch_en),
        .mul_op   (mul_op),
        .zero_a   (zero_a),
        .target_b (target_b),
        .j_imm    (j_imm),
        .pc       (pc),
        .imem_rd  (imem_rd),
        .ir       (ir),
        .ir_valid (ir_valid),
        .stage_adv(stage_adv),
        .mul_en   (mul_en),
        .reg_we   (reg_we),
        .busy     (busy),
        .halted   (halted)
    );

    // Instruction memory for run mode: data valid the cycle after imem_rd.
    logic [15:0] mem [0:7];
    always @(posedge CLOCK_50) begin
        if (imem_rd) mem_instr <= mem[pc[2:0]];
    end

    typedef struct packed {
        logic [15:0] instr;
        logic        mul_op;
        logic        jump_en;
        logic        branch_en;
        logic        zero_a;
        logic [11:0] j_imm;
        logic [11:0] target_b;
        logic [11:0] fetch_pc;
        logic [11:0] next_pc;
        logic [31:0] cycles;
        logic [31:0] mul_cycles;
    } vec_t;

    typedef struct packed {
        logic [11:0] fetch_pc;
        logic [15:0] ir;
        logic [11:0] next_pc;
    } exp_t;

    vec_t vec [8];
    exp_t sb_q [$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"}, {20'd0, pc}, 0);
        check({tag, "_ir"}, {16'd0, ir}, 0);
        check({tag, "_flags"}, {25'd0, ir_valid, imem_rd, stage_adv, mul_en, reg_we, busy, halted}, 0);
    endtask

    task automatic do_reset(input string tag);
        reset  = 1'b1;
        step_n = 1'b1;
        run    = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        check_reset_state(tag);
    endtask

    // Scoreboard: each WB pops one expectation; the new PC is checked the following cycle.
    task automatic monitor();
        exp_t        e;
        logic [11:0] fetch_seen;
        logic [11:0] pend_pc;
        logic        pend;
        pend       = 1'b0;
        fetch_seen = '0;
        pend_pc    = '0;
        forever begin
            @(negedge CLOCK_50);
            if (pend) begin
                check("pc_after_wb", {20'd0, pc}, {20'd0, pend_pc});
                pend = 1'b0;
            end
            if (imem_rd) fetch_seen = pc;
            if (reg_we) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_reg_we: got reg_we with pc %0h, expected no write", pc);
                end else begin
                    e = sb_q.pop_front();
                    check("ir_at_wb", {16'd0, ir}, {16'd0, e.ir});
                    check("fetch_addr", {20'd0, fetch_seen}, {20'd0, e.fetch_pc});
                    pend_pc = e.next_pc;
                    pend    = 1'b1;
                    $display("wb: fetch %03h ir %04h expect next pc %03h", fetch_seen, ir, e.next_pc);
                end
            end
        end
    endtask

    // Press the key, then measure step->fetch latency, busy length and mul_en length.
    task automatic step_instr(output int lat, output int bcyc, output int mcyc);
        int t;
        lat  = 0;
        bcyc = 0;
        mcyc = 0;
        t    = 0;
        step_n = 1'b0;
        do begin
            @(negedge CLOCK_50);
            lat++;
            t++;
        end while (!imem_rd && t < 50);
        while (busy && t < 100) begin
            bcyc++;
            if (mul_en) mcyc++;
            if (bcyc == 2) step_n = 1'b1;
            @(negedge CLOCK_50);
            t++;
        end
        step_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bcyc, mcyc, t, cnt;
        //           instr     mul  jmp  br   zero j_imm    tgt_b    fetch    next     cyc mulc
        vec[0] = '{16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 12'h000, 12'h001, 32'd4, 32'd0};
        vec[1] = '{16'h2000, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 12'h001, 12'h002, 32'd8, 32'd4};
        vec[2] = '{16'h3000, 1'b0, 1'b1, 1'b1, 1'b1, 12'h0A5, 12'h033, 12'h002, 12'h0A5, 32'd4, 32'd0};
        vec[3] = '{16'h3001, 1'b0, 1'b0, 1'b1, 1'b1, 12'h0A5, 12'h033, 12'h0A5, 12'h033, 32'd4, 32'd0};
        vec[4] = '{16'h3002, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0A5, 12'h033, 12'h033, 12'h034, 32'd4, 32'd0};
        vec[5] = '{16'h4000, 1'b0, 1'b1, 1'b0, 1'b0, 12'hFFF, 12'h033, 12'h034, 12'hFFF, 32'd4, 32'd0};
        vec[6] = '{16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 12'hFFF, 12'h000, 32'd4, 32'd0};
        vec[7] = '{16'h5000, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000, 12'h7FF, 12'h000, 12'h7FF, 32'd8, 32'd4};

        mem[0] = 16'h1000; mem[1] = 16'h1001; mem[2] = 16'h1002; mem[3] = 16'hF000;
        mem[4] = 16'h0000; mem[5] = 16'h0000; mem[6] = 16'h0000; mem[7] = 16'h0000;

        fork
            monitor();
        join_none

        // Single-step table
        do_reset("reset");
        for (int i = 0; i < 8; i++) begin
            tbl_instr = vec[i].instr;
            mul_op    = vec[i].mul_op;
            jump_en   = vec[i].jump_en;
            branch_en = vec[i].branch_en;
            zero_a    = vec[i].zero_a;
            j_imm     = vec[i].j_imm;
            target_b  = vec[i].target_b;
            sb_q.push_back('{vec[i].fetch_pc, vec[i].instr, vec[i].next_pc});
            step_instr(lat, bcyc, mcyc);
            check("step_latency", lat, 3);
            check("busy_cycles", bcyc, vec[i].cycles);
            check("mul_en_cycles", mcyc, vec[i].mul_cycles);
            check("ir_valid", {31'd0, ir_valid}, 1);
            $display("vec %0d: instr %04h latency %0d busy %0d mul_en %0d", i, vec[i].instr, lat, bcyc, mcyc);
        end
        @(negedge CLOCK_50);
        check("sb_empty_table", sb_q.size(), 0);

        // Free-run to a HALT at pc 3
        do_reset("reset_run");
        use_mem = 1'b1;
        mul_op = 1'b0; jump_en = 1'b0; branch_en = 1'b0; zero_a = 1'b0;
        sb_q.push_back('{12'h000, 16'h1000, 12'h001});
        sb_q.push_back('{12'h001, 16'h1001, 12'h002});
        sb_q.push_back('{12'h002, 16'h1002, 12'h003});
        run = 1'b1;
        cnt = 0;
        do begin
            @(negedge CLOCK_50);
            cnt++;
        end while (!halted && cnt < 100);
        check("halt_latency", cnt, 15);
        check("halt_pc", {20'd0, pc}, 12'h003);
        check("halt_ir", {16'd0, ir}, 16'hF000);
        check("halt_busy", {31'd0, busy}, 0);
        check("sb_empty_run", sb_q.size(), 0);
        $display("run: halted after %0d cycles at pc %03h", cnt, pc);
        run = 1'b0;
        step_n = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge CLOCK_50);
            if (imem_rd || busy) cnt++;
        end
        step_n = 1'b1;
        check("halted_step_ignored", cnt, 0);
        check("still_halted", {31'd0, halted}, 1);
        check("halted_pc_frozen", {20'd0, pc}, 12'h003);

        // Step pressed during MUL_WAIT is dropped
        do_reset("reset_mul");
        use_mem = 1'b0;
        tbl_instr = 16'h2222;
        mul_op = 1'b1; jump_en = 1'b0; branch_en = 1'b0; zero_a = 1'b0;
        sb_q.push_back('{12'h000, 16'h2222, 12'h001});
        step_n = 1'b0;
        t = 0;
        do begin @(negedge CLOCK_50); t++; end while (!imem_rd && t < 50);
        step_n = 1'b1;
        t = 0;
        do begin @(negedge CLOCK_50); t++; end while (!mul_en && t < 50);
        check("reached_mul_wait", {31'd0, mul_en}, 1);
        step_n = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        step_n = 1'b1;
        t = 0;
        while (busy && t < 50) begin @(negedge CLOCK_50); t++; end
        cnt = 0;
        repeat (10) begin
            @(negedge CLOCK_50);
            if (imem_rd || busy) cnt++;
        end
        check("step_dropped_in_mul", cnt, 0);
        check("pc_after_mul", {20'd0, pc}, 12'h001);
        $display("mul: step during MUL_WAIT, extra busy cycles %0d, pc %03h", cnt, pc);

        // Reset while in EXEC aborts the instruction
        tbl_instr = 16'h3333;
        mul_op = 1'b0;
        step_n = 1'b0;
        t = 0;
        do begin @(negedge CLOCK_50); t++; end while (!imem_rd && t < 50);
        step_n = 1'b1;
        t = 0;
        do begin @(negedge CLOCK_50); t++; end while (!stage_adv && t < 50);
        check("reached_exec", {31'd0, stage_adv}, 1);
        reset = 1'b1;
        @(negedge CLOCK_50);
        check_reset_state("exec_reset");
        reset = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(negedge CLOCK_50);
            if (reg_we || busy) cnt++;
        end
        check("no_activity_after_abort", cnt, 0);
        check("pc_after_abort", {20'd0, pc}, 0);
        check("sb_empty_end", sb_q.size(), 0);
        $display("abort: reset in EXEC, pc %03h, activity %0d", pc, cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
